// File: rtl/reg_file_wb.sv
// Register file with a one-entry write-back latch and two bypassed read ports.
// Writes commit to the array one edge after capture; reads see the latch first.
module reg_file_wb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              wb_pending,
    output logic [7:0]        commit_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              cap;

    // Writes aimed at a hardwired r0 never enter the latch.
    assign cap = RegWrite && !(ZERO_REG && (WriteReg == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            commit_cnt <= '0;
        end else begin
            if (wb_valid) begin
                regs[wb_addr] <= wb_data;
                commit_cnt    <= commit_cnt + 8'd1;
            end
            wb_valid <= cap;
            if (cap) begin
                wb_addr <= WriteReg;
                wb_data <= WriteData;
            end
        end
    end

    assign wb_pending = wb_valid;

    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (ZERO_REG && (ReadReg1 == '0)) begin
            ReadData1 = '0;
        end else if (wb_valid && (wb_addr == ReadReg1)) begin
            ReadData1 = wb_data;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (ZERO_REG && (ReadReg2 == '0)) begin
            ReadData2 = '0;
        end else if (wb_valid && (wb_addr == ReadReg2)) begin
            ReadData2 = wb_data;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: stimulus queues expectations,
// a negedge monitor pops and compares them against both DUT instances.
module tb_reg_file_wb;

    typedef struct {
        int          kind;
        int          addr;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic [2:0]  ReadReg1;
    logic [2:0]  ReadReg2;
    logic [15:0] ReadData1, ReadData2;
    logic        wb_pending;
    logic [7:0]  commit_cnt;
    logic [15:0] rd1_0, rd2_0;
    logic        pend0;
    logic [7:0]  cnt0;

    chk_t        q[$];
    chk_t        c;
    logic [15:0] act;
    logic [15:0] mdl [8];
    int          checks = 0;
    int          errors = 0;

    reg_file_wb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .wb_pending(wb_pending), .commit_cnt(commit_cnt)
    );

    reg_file_wb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_0), .ReadData2(rd2_0),
        .wb_pending(pend0), .commit_cnt(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kinds: 0 rd1, 1 rd2, 2 pending, 3 cnt, 4 dut0 rd1,
    // 5 array entry, 6 dut0 pending, 7 dut0 cnt, 8 dut0 rd2
    always @(negedge clk) begin
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.kind)
                0: act = ReadData1;
                1: act = ReadData2;
                2: act = {15'd0, wb_pending};
                3: act = {8'd0, commit_cnt};
                4: act = rd1_0;
                5: act = dut.regs[c.addr];
                6: act = {15'd0, pend0};
                7: act = {8'd0, cnt0};
                default: act = rd2_0;
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [15:0] exp,
                            input string name, input int addr = 0);
        chk_t e;
        e.kind = kind;
        e.addr = addr;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        RegWrite  = 1'b1;
        WriteReg  = a;
        WriteData = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] a;
        logic [2:0] ra;
        logic [15:0] d;
        rst = 1'b1;
        RegWrite = 1'b1;
        WriteReg = 3'd4;
        WriteData = 16'hDEAD;
        ReadReg1 = '0;
        ReadReg2 = '0;
        tick();
        rst = 1'b0;
        RegWrite = 1'b0;

        // reset state on every address
        for (int i = 0; i < 8; i++) begin
            ReadReg1 = 3'(i);
            ReadReg2 = 3'(i);
            expect_v(0, 16'h0, "reset_rd1");
            expect_v(1, 16'h0, "reset_rd2");
            expect_v(2, 16'h0, "reset_pending");
            expect_v(3, 16'h0, "reset_cnt");
            expect_v(7, 16'h0, "reset_cnt_z0");
            tick();
        end

        // r3 = 0x1234: no same-cycle bypass, then bypass, then array
        ReadReg1 = 3'd3;
        wr(3'd3, 16'h1234);
        expect_v(0, 16'h0000, "r3_before");
        tick();
        RegWrite = 1'b0;
        expect_v(0, 16'h1234, "r3_bypass");
        expect_v(2, 16'h1, "r3_pending");
        expect_v(3, 16'h0, "r3_cnt0");
        tick();
        expect_v(0, 16'h1234, "r3_array");
        expect_v(2, 16'h0, "r3_pending_clr");
        expect_v(3, 16'h1, "r3_cnt1");
        expect_v(5, 16'h1234, "r3_arr", 3);
        tick();

        // r0 write: dropped with ZERO_REG=1, kept with ZERO_REG=0
        ReadReg1 = 3'd0;
        ReadReg2 = 3'd0;
        wr(3'd0, 16'hFFFF);
        tick();
        RegWrite = 1'b0;
        expect_v(0, 16'h0, "r0_zero_rd1");
        expect_v(2, 16'h0, "r0_no_pending");
        expect_v(3, 16'h1, "r0_cnt_same");
        expect_v(4, 16'hFFFF, "r0_z0_bypass");
        expect_v(6, 16'h1, "r0_z0_pending");
        tick();
        expect_v(0, 16'h0, "r0_zero_later");
        expect_v(3, 16'h1, "r0_cnt_later");
        expect_v(4, 16'hFFFF, "r0_z0_rd1");
        expect_v(8, 16'hFFFF, "r0_z0_rd2");
        expect_v(7, 16'h2, "r0_z0_cnt");
        tick();

        // back-to-back r5 = 0xAA, 0xBB
        ReadReg1 = 3'd5;
        ReadReg2 = 3'd5;
        wr(3'd5, 16'h00AA);
        tick();
        wr(3'd5, 16'h00BB);
        expect_v(0, 16'h00AA, "b2b_e1_rd1");
        expect_v(1, 16'h00AA, "b2b_e1_rd2");
        tick();
        RegWrite = 1'b0;
        expect_v(0, 16'h00BB, "b2b_e2_rd1");
        expect_v(5, 16'h00AA, "b2b_e2_arr", 5);
        expect_v(2, 16'h1, "b2b_e2_pending");
        tick();
        expect_v(0, 16'h00BB, "b2b_e3_rd1");
        expect_v(5, 16'h00BB, "b2b_e3_arr", 5);
        expect_v(2, 16'h0, "b2b_e3_pending");
        expect_v(3, 16'h3, "b2b_e3_cnt");
        tick();

        // reset drops a pending write
        ReadReg1 = 3'd2;
        ReadReg2 = 3'd3;
        wr(3'd2, 16'h5555);
        tick();
        RegWrite = 1'b0;
        rst = 1'b1;
        expect_v(0, 16'h5555, "drop_bypass");
        expect_v(2, 16'h1, "drop_pending");
        tick();
        rst = 1'b0;
        expect_v(0, 16'h0, "drop_r2");
        expect_v(1, 16'h0, "drop_r3");
        expect_v(2, 16'h0, "drop_pending_clr");
        expect_v(3, 16'h0, "drop_cnt");
        tick();
        expect_v(0, 16'h0, "drop_r2_later");
        expect_v(3, 16'h0, "drop_cnt_later");
        tick();

        // 256 writes across r1..r7, commit_cnt wraps
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
        for (int i = 0; i < 256; i++) begin
            a  = 3'(1 + (i % 7));
            ra = 3'(1 + ((i + 3) % 7));
            d  = 16'(i * 16'h0101 + 16'h0011);
            wr(a, d);
            ReadReg1 = ra;
            ReadReg2 = ra;
            expect_v(0, mdl[ra], "wrap_rd1");
            expect_v(1, mdl[ra], "wrap_rd2");
            tick();
            mdl[a] = d;
        end
        RegWrite = 1'b0;
        expect_v(2, 16'h1, "wrap_pending");
        expect_v(3, 16'd255, "wrap_cnt255");
        tick();
        expect_v(2, 16'h0, "wrap_pending_clr");
        expect_v(3, 16'd0, "wrap_cnt0");
        tick();

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
